// File: rtl/mmio_responder.sv
// -----------------------------------------------------------------------------
// mmio_responder
//   Memory-mapped I/O responder for the CPU memory bus. It answers loads and
//   stores to the I/O page: LEDs, a 16-bit hex-display register, synchronized
//   switches, a switch-change event flag and a free-running cycle counter.
//   RAM keeps serving every other address; the top level picks io_rdata over
//   RAM read data whenever io_hit is high.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high
//   mem_cmd     bus command: 00 none, 01 read, 10 write, 11 treated as none
//   mem_addr    access address
//   write_data  store data
//   sw_in       raw switches, asynchronous to clk
//   io_rdata    registered read data (zero when not a mapped read)
//   io_hit      registered: io_rdata holds data of a mapped read this cycle
//   ledr        LED register contents
//   hex0..hex3  active-low seven-segment digits (bit6=g .. bit0=a)
// -----------------------------------------------------------------------------
module mmio_responder #(
    parameter int                ADDR_W   = 9,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
    parameter logic [ADDR_W-1:0] HEX_ADDR = 9'h120,
    parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140,
    parameter logic [ADDR_W-1:0] EVT_ADDR = 9'h141,
    parameter logic [ADDR_W-1:0] CNT_ADDR = 9'h160
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [7:0]        sw_in,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_hit,
    output logic [7:0]        ledr,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3
);

    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    // Active-low hex digit decode, 0-F.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [7:0]        sw_s1_r;
    logic [7:0]        sw_s2_r;
    logic [7:0]        sw_prev_r;
    logic [7:0]        led_r;
    logic [15:0]       hex_r;
    logic [15:0]       cnt_r;
    logic              evt_r;
    logic [DATA_W-1:0] rdata_r;
    logic              hit_r;

    logic              is_read_s;
    logic              is_write_s;
    logic              sw_change_s;
    logic              evt_clr_s;
    logic              rd_map_s;
    logic [DATA_W-1:0] rd_val_s;
    logic              wr_led_s;
    logic              wr_hex_s;
    logic              wr_cnt_s;

    assign is_read_s   = (mem_cmd == MREAD);
    assign is_write_s  = (mem_cmd == MWRITE);
    assign sw_change_s = (sw_s2_r != sw_prev_r);
    assign evt_clr_s   = is_read_s && (mem_addr == EVT_ADDR);

    // Address decode: read mux over pre-edge register values, write strobes.
    always_comb begin
        rd_map_s = 1'b0;
        rd_val_s = {DATA_W{1'b0}};
        wr_led_s = 1'b0;
        wr_hex_s = 1'b0;
        wr_cnt_s = 1'b0;
        case (mem_addr)
            LED_ADDR: begin
                rd_map_s = 1'b1;
                rd_val_s = DATA_W'(led_r);
                wr_led_s = is_write_s;
            end
            HEX_ADDR: begin
                rd_map_s = 1'b1;
                rd_val_s = DATA_W'(hex_r);
                wr_hex_s = is_write_s;
            end
            SW_ADDR: begin
                rd_map_s = 1'b1;
                rd_val_s = DATA_W'(sw_s2_r);
            end
            EVT_ADDR: begin
                rd_map_s = 1'b1;
                rd_val_s = DATA_W'(evt_r);
            end
            CNT_ADDR: begin
                rd_map_s = 1'b1;
                rd_val_s = DATA_W'(cnt_r);
                wr_cnt_s = is_write_s;
            end
            default: begin
                rd_map_s = 1'b0;
                rd_val_s = {DATA_W{1'b0}};
            end
        endcase
    end

    // Switch synchronizer and previous-value register for change detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1_r   <= 8'h00;
            sw_s2_r   <= 8'h00;
            sw_prev_r <= 8'h00;
        end else begin
            sw_s1_r   <= sw_in;
            sw_s2_r   <= sw_s1_r;
            sw_prev_r <= sw_s2_r;
        end
    end

    // Event flag: a change sets it, an accepted read clears it, set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_r <= 1'b0;
        end else if (sw_change_s) begin
            evt_r <= 1'b1;
        end else if (evt_clr_s) begin
            evt_r <= 1'b0;
        end else begin
            evt_r <= evt_r;
        end
    end

    // Cycle counter. A write makes the write cycle itself count as zero, so
    // the register holds 1 after that edge and a read issued next returns 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= 16'h0000;
        end else if (wr_cnt_s) begin
            cnt_r <= 16'h0001;
        end else begin
            cnt_r <= cnt_r + 16'h0001;
        end
    end

    // LED and hex-display registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_r <= 8'h00;
            hex_r <= 16'h0000;
        end else begin
            if (wr_led_s) begin
                led_r <= write_data[7:0];
            end else begin
                led_r <= led_r;
            end
            if (wr_hex_s) begin
                hex_r <= write_data[15:0];
            end else begin
                hex_r <= hex_r;
            end
        end
    end

    // One-cycle read response; anything other than a mapped read returns 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_r   <= 1'b0;
            rdata_r <= {DATA_W{1'b0}};
        end else if (is_read_s && rd_map_s) begin
            hit_r   <= 1'b1;
            rdata_r <= rd_val_s;
        end else begin
            hit_r   <= 1'b0;
            rdata_r <= {DATA_W{1'b0}};
        end
    end

    assign io_hit   = hit_r;
    assign io_rdata = rdata_r;
    assign ledr     = led_r;
    assign hex0     = seg7(hex_r[3:0]);
    assign hex1     = seg7(hex_r[7:4]);
    assign hex2     = seg7(hex_r[11:8]);
    assign hex3     = seg7(hex_r[15:12]);

endmodule

// File: tb/tb_mmio_responder.sv
// -----------------------------------------------------------------------------
// tb_mmio_responder
//   Directed stimulus with hand-computed expectations, plus a bench-side model
//   of the I/O page compared against every DUT output on every falling edge.
// -----------------------------------------------------------------------------
module tb_mmio_responder;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;
    localparam logic [1:0] MBAD   = 2'b11;
    localparam logic [8:0] LED_A  = 9'h100;
    localparam logic [8:0] HEX_A  = 9'h120;
    localparam logic [8:0] SW_A   = 9'h140;
    localparam logic [8:0] EVT_A  = 9'h141;
    localparam logic [8:0] CNT_A  = 9'h160;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic [1:0]  mem_cmd    = 2'b00;
    logic [8:0]  mem_addr   = 9'h000;
    logic [15:0] write_data = 16'h0000;
    logic [7:0]  sw_in      = 8'h00;
    logic [15:0] io_rdata;
    logic        io_hit;
    logic [7:0]  ledr;
    logic [6:0]  hex0, hex1, hex2, hex3;

    int n_tests = 0;
    int n_fail  = 0;

    mmio_responder dut (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .write_data(write_data), .sw_in(sw_in), .io_rdata(io_rdata),
        .io_hit(io_hit), .ledr(ledr), .hex0(hex0), .hex1(hex1),
        .hex2(hex2), .hex3(hex3)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Counter value after edge k is (k - cnt_base) mod 2^16.
    // sw_log[i] = sw_in as sampled i+1 edges ago (zeros after reset);
    // software sees the sample from two edges back.
    logic        m_valid = 1'b0;
    logic [7:0]  m_led   = 8'h00;
    logic [15:0] m_hex   = 16'h0000;
    logic        m_evt   = 1'b0;
    logic        m_hit   = 1'b0;
    logic [15:0] m_rdata = 16'h0000;
    int          edge_k  = 0;
    int          cnt_base = 0;
    logic [7:0]  sw_log [0:2] = '{8'h00, 8'h00, 8'h00};

    always @(posedge clk) begin
        edge_k <= edge_k + 1;
        if (reset) begin
            m_valid  <= 1'b1;
            m_led    <= 8'h00;
            m_hex    <= 16'h0000;
            m_evt    <= 1'b0;
            m_hit    <= 1'b0;
            m_rdata  <= 16'h0000;
            cnt_base <= edge_k;
            sw_log   <= '{8'h00, 8'h00, 8'h00};
        end else begin
            m_hit   <= 1'b0;
            m_rdata <= 16'h0000;
            if (mem_cmd == MREAD) begin
                case (mem_addr)
                    LED_A: begin m_hit <= 1'b1; m_rdata <= {8'h00, m_led}; end
                    HEX_A: begin m_hit <= 1'b1; m_rdata <= m_hex; end
                    SW_A:  begin m_hit <= 1'b1; m_rdata <= {8'h00, sw_log[1]}; end
                    EVT_A: begin m_hit <= 1'b1; m_rdata <= {15'b0, m_evt}; end
                    CNT_A: begin m_hit <= 1'b1; m_rdata <= 16'(edge_k - 1 - cnt_base); end
                    default: ;
                endcase
            end
            if (mem_cmd == MWRITE) begin
                case (mem_addr)
                    LED_A: m_led <= write_data[7:0];
                    HEX_A: m_hex <= write_data;
                    CNT_A: cnt_base <= edge_k - 1;
                    default: ;
                endcase
            end
            m_evt <= (sw_log[1] != sw_log[2]) ||
                     (m_evt && !(mem_cmd == MREAD && mem_addr == EVT_A));
            sw_log <= '{sw_in, sw_log[0], sw_log[1]};
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model", 64'({io_hit, io_rdata, ledr, hex3, hex2, hex1, hex0}),
                64'({m_hit, m_rdata, m_led, seg_tab[m_hex[15:12]], seg_tab[m_hex[11:8]],
                     seg_tab[m_hex[7:4]], seg_tab[m_hex[3:0]]}));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle(input int n);
        mem_cmd = MNONE;
        repeat (n) @(negedge clk);
    endtask

    task automatic op(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        mem_cmd    = c;
        mem_addr   = a;
        write_data = d;
        @(negedge clk);
        mem_cmd = MNONE;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state and counter start
        idle(3);
        chk("rst_ledr", 64'(ledr), 64'h00);
        chk("rst_hex", 64'({hex3, hex2, hex1, hex0}), 64'({7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}));
        chk("rst_hit", 64'(io_hit), 64'h0);
        op(MREAD, CNT_A, 16'h0000);
        chk("cnt_after_reset", 64'({io_hit, io_rdata}), 64'({1'b1, 16'd3}));

        // LED write/read
        op(MWRITE, LED_A, 16'h00A5);
        chk("led_out", 64'(ledr), 64'hA5);
        op(MREAD, LED_A, 16'h0000);
        chk("led_read", 64'({io_hit, io_rdata}), 64'({1'b1, 16'h00A5}));
        idle(1);
        chk("hit_pulse_end", 64'(io_hit), 64'h0);

        // Hex write/read, back-to-back reads
        op(MWRITE, HEX_A, 16'h12EF);
        chk("hex_digits", 64'({hex3, hex2, hex1, hex0}),
            64'({7'b1111001, 7'b0100100, 7'b0000110, 7'b0001110}));
        op(MREAD, HEX_A, 16'h0000);
        chk("hex_read", 64'({io_hit, io_rdata}), 64'({1'b1, 16'h12EF}));
        op(MREAD, LED_A, 16'h0000);
        chk("b2b_read", 64'({io_hit, io_rdata}), 64'({1'b1, 16'h00A5}));

        // Switch synchronizer delay
        sw_in = 8'h3C;
        op(MREAD, SW_A, 16'h0000);
        chk("sw_delay1", 64'(io_rdata), 64'h0000);
        op(MREAD, SW_A, 16'h0000);
        chk("sw_delay2", 64'(io_rdata), 64'h0000);
        op(MREAD, SW_A, 16'h0000);
        chk("sw_synced", 64'({io_hit, io_rdata}), 64'({1'b1, 16'h003C}));

        // Event flag read-to-clear
        op(MREAD, EVT_A, 16'h0000);
        chk("evt_set", 64'(io_rdata), 64'h1);
        op(MREAD, EVT_A, 16'h0000);
        chk("evt_cleared", 64'({io_hit, io_rdata}), 64'({1'b1, 16'h0000}));

        // Change detect coinciding with the clearing read: set wins
        sw_in = 8'hFF;
        idle(1);
        sw_in = 8'h00;
        idle(2);
        op(MREAD, EVT_A, 16'h0000);
        chk("evt_before_clash", 64'(io_rdata), 64'h1);
        op(MREAD, EVT_A, 16'h0000);
        chk("evt_set_wins", 64'(io_rdata), 64'h1);
        op(MREAD, EVT_A, 16'h0000);
        chk("evt_final_clear", 64'(io_rdata), 64'h0);

        // Counter clear and wrap
        op(MWRITE, CNT_A, 16'h1234);
        op(MREAD, CNT_A, 16'h0000);
        chk("cnt_clear", 64'({io_hit, io_rdata}), 64'({1'b1, 16'h0001}));
        idle(65535);
        op(MREAD, CNT_A, 16'h0000);
        chk("cnt_wrap", 64'({io_hit, io_rdata}), 64'({1'b1, 16'h0001}));

        // Unmapped read, ignored write, illegal command
        op(MREAD, 9'h0FF, 16'h0000);
        chk("unmapped_read", 64'({io_hit, io_rdata}), 64'h0);
        op(MWRITE, SW_A, 16'hFFFF);
        op(MBAD, LED_A, 16'h0000);
        chk("cmd11_nohit", 64'({io_hit, io_rdata}), 64'h0);
        op(MWRITE, EVT_A, 16'hFFFF);
        op(MREAD, SW_A, 16'h0000);
        chk("sw_unchanged", 64'({io_hit, io_rdata}), 64'({1'b1, 16'h0000}));
        op(MREAD, HEX_A, 16'h0000);
        chk("hex_unchanged", 64'(io_rdata), 64'h12EF);
        chk("led_unchanged", 64'(ledr), 64'hA5);

        // Reset during a read
        mem_cmd  = MREAD;
        mem_addr = LED_A;
        reset    = 1'b1;
        @(negedge clk);
        chk("rst_mid_hit", 64'({io_hit, io_rdata}), 64'h0);
        chk("rst_mid_ledr", 64'(ledr), 64'h00);
        chk("rst_mid_hex0", 64'(hex0), 64'(7'b1000000));
        reset   = 1'b0;
        mem_cmd = MNONE;
        idle(1);
        op(MREAD, CNT_A, 16'h0000);
        chk("cnt_after_rst2", 64'(io_rdata), 64'd1);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
